// File: rtl/key_pkg.sv
// Shared types and constants for the key debouncer.
// Release-flag port is controlled by KEY_DEBOUNCE_RELEASE_FLAG_EN.
package key_pkg;

  typedef enum logic [1:0] {
    REL       = 2'd0,
    DEB_PRESS = 2'd1,
    PRS       = 2'd2,
    DEB_REL   = 2'd3
  } key_state_e;

  localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;

  // Counter width; keeps at least one bit for CNT_MAX of 1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key-side signal bundle for the debouncer.
// key_rel_flag exists only with KEY_DEBOUNCE_RELEASE_FLAG_EN.
interface key_debounce_if;

  logic key_in;
  logic key_out;
  logic key_flag;
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
  logic key_rel_flag;
`endif

  modport master (
    output key_in,
    input  key_out,
    input  key_flag
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
    ,
    input  key_rel_flag
`endif
  );

  modport slave (
    input  key_in,
    output key_out,
    output key_flag
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
    ,
    output key_rel_flag
`endif
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Reset value is a parameter so it can match the idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/key_debounce.sv
// Key debouncer: 2-flop sync, 4-state FSM, press/release pulses.
// KEY_DEBOUNCE_RELEASE_FLAG_EN adds the key_rel_flag output.
module key_debounce
  import key_pkg::*;
#(
  parameter int   CNT_MAX    = DEBOUNCE_20MS_50MHZ,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_out,
  output logic key_flag
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
  ,
  output logic key_rel_flag
`endif
);

  localparam int CW = cnt_w(CNT_MAX);
  // The cycle that leaves a stable state is the first counted one.
  localparam logic [CW-1:0] ACC =
    CW'((CNT_MAX >= 2) ? CNT_MAX - 2 : 0);

  logic       w_key_s;
  logic       w_prs;
  logic       w_busy;
  logic       w_direct;

  key_state_e r_state;
  key_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic       r_key_out;
  logic       w_key_out_nxt;
  logic       r_flag;
  logic       w_flag_nxt;
  logic       r_rel;
  logic       w_rel_nxt;

  sync_2ff #(
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (key_in),
    .o_q     (w_key_s)
  );

  assign w_prs    = (w_key_s != IDLE_LEVEL);
  // Never let two pulses land on adjacent cycles.
  assign w_busy   = r_flag | r_rel;
  assign w_direct = (CNT_MAX == 1) && !w_busy;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_key_out_nxt = r_key_out;
    w_flag_nxt    = 1'b0;
    w_rel_nxt     = 1'b0;
    unique case (r_state)
      REL: begin
        if (w_prs) begin
          if (w_direct) begin
            w_state_nxt   = PRS;
            w_key_out_nxt = ~IDLE_LEVEL;
            w_flag_nxt    = 1'b1;
          end else begin
            w_state_nxt = DEB_PRESS;
          end
        end
      end
      DEB_PRESS: begin
        if (!w_prs) begin
          w_state_nxt = REL;
        end else if (r_cnt == ACC) begin
          w_state_nxt   = PRS;
          w_key_out_nxt = ~IDLE_LEVEL;
          w_flag_nxt    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRS: begin
        if (!w_prs) begin
          if (w_direct) begin
            w_state_nxt   = REL;
            w_key_out_nxt = IDLE_LEVEL;
            w_rel_nxt     = 1'b1;
          end else begin
            w_state_nxt = DEB_REL;
          end
        end
      end
      DEB_REL: begin
        if (w_prs) begin
          w_state_nxt = PRS;
        end else if (r_cnt == ACC) begin
          w_state_nxt   = REL;
          w_key_out_nxt = IDLE_LEVEL;
          w_rel_nxt     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = REL;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= REL;
      r_cnt     <= '0;
      r_key_out <= IDLE_LEVEL;
      r_flag    <= 1'b0;
      r_rel     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_key_out <= w_key_out_nxt;
      r_flag    <= w_flag_nxt;
      r_rel     <= w_rel_nxt;
    end
  end

  assign key_out  = r_key_out;
  assign key_flag = r_flag;
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
  assign key_rel_flag = r_rel;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce, CNT_MAX=10, IDLE_LEVEL=1.
// Flag timing is checked against a queue of expected edge numbers.
module tb_key_debounce;
  import key_pkg::*;

  localparam int CM  = 10;
  localparam int LAT = CM + 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   tests;
  int   fails;
  bit   mon_en;
  bit   prev_flag;
  int   flag_q[$];
  int   rel_q[$];

  key_debounce_if kif();

  key_debounce #(
    .CNT_MAX    (CM),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .key_in       (kif.key_in),
    .key_out      (kif.key_out),
    .key_flag     (kif.key_flag)
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
    ,
    .key_rel_flag (kif.key_rel_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // Scoreboard: every observed pulse must match a queued edge number.
  always @(negedge clk) begin
    if (mon_en) begin
      if (kif.key_flag) begin
        tests++;
        if (flag_q.size() == 0) begin
          fails++;
          $display("FAIL key_flag_unexpected: pulse at edge %0d, none required", cyc);
        end else begin
          automatic int e = flag_q.pop_front();
          if (cyc !== e) begin
            fails++;
            $display("FAIL key_flag_time: pulse at edge %0d, required %0d", cyc, e);
          end
        end
        tests++;
        if (kif.key_out !== 1'b0) begin
          fails++;
          $display("FAIL key_out_at_flag: got %b, required 0", kif.key_out);
        end
        if (prev_flag) begin
          fails++;
          $display("FAIL key_flag_width: high 2 cycles at edge %0d, required 1", cyc);
        end
      end
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
      if (kif.key_rel_flag) begin
        tests++;
        if (rel_q.size() == 0) begin
          fails++;
          $display("FAIL rel_flag_unexpected: pulse at edge %0d, none required", cyc);
        end else begin
          automatic int e = rel_q.pop_front();
          if (cyc !== e) begin
            fails++;
            $display("FAIL rel_flag_time: pulse at edge %0d, required %0d", cyc, e);
          end
        end
        tests++;
        if (kif.key_out !== 1'b1 || kif.key_flag) begin
          fails++;
          $display("FAIL rel_flag_state: key_out=%b key_flag=%b, required 1/0",
                   kif.key_out, kif.key_flag);
        end
      end
`endif
    end
    prev_flag = kif.key_flag;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic exp);
    @(negedge clk);
    tests++;
    if (kif.key_out !== exp) begin
      fails++;
      $display("FAIL %s: key_out=%b, required %b", nm, kif.key_out, exp);
    end
  endtask

  task automatic press();
    kif.key_in = 1'b0;
    flag_q.push_back(cyc + LAT);
  endtask

  task automatic release_key();
    kif.key_in = 1'b1;
`ifdef KEY_DEBOUNCE_RELEASE_FLAG_EN
    rel_q.push_back(cyc + LAT);
`endif
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    kif.key_in = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (kif.key_out !== 1'b1 || kif.key_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: key_out=%b key_flag=%b, required 1/0",
               kif.key_out, kif.key_flag);
    end
    kif.key_in = 1'b1;
    tick(1);
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick(4);
  endtask

  task automatic test_clean_press();
    press();
    tick(LAT - 1);
    chk_out("press_before", 1'b1);
    tick(1);
    chk_out("press_after", 1'b0);
    tick(4);
    release_key();
    tick(LAT - 1);
    chk_out("release_before", 1'b0);
    tick(1);
    chk_out("release_after", 1'b1);
    tick(4);
  endtask

  task automatic test_bounce();
    kif.key_in = 1'b0;
    tick(5);
    kif.key_in = 1'b1;
    tick(2);
    press();
    tick(LAT + 4);
    chk_out("bounce_pressed", 1'b0);
    release_key();
    tick(LAT + 4);
  endtask

  task automatic test_glitch();
    kif.key_in = 1'b0;
    tick(CM - 1);
    kif.key_in = 1'b1;
    tick(LAT + 6);
    chk_out("glitch_key_out", 1'b1);
    tests++;
    if (dut.r_state !== REL) begin
      fails++;
      $display("FAIL glitch_state: state=%0d, required %0d", dut.r_state, REL);
    end
  endtask

  task automatic test_min_hold();
    press();
    tick(CM);
    release_key();
    tick(LAT + 6);
    chk_out("min_hold_released", 1'b1);
  endtask

  task automatic test_reset_mid();
    kif.key_in = 1'b0;
    tick(9);
    rst_n = 1'b0;
    #1;
    tests++;
    if (kif.key_out !== 1'b1 || kif.key_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: key_out=%b key_flag=%b, required 1/0",
               kif.key_out, kif.key_flag);
    end
    tick(3);
    rst_n = 1'b1;
    flag_q.push_back(cyc + LAT);
    tick(LAT - 1);
    chk_out("reset_mid_before", 1'b1);
    tick(1);
    chk_out("reset_mid_after", 1'b0);
    tick(3);
    rst_n = 1'b0;
    #1;
    tests++;
    if (kif.key_out !== 1'b1 || kif.key_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_prs_outputs: key_out=%b key_flag=%b, required 1/0",
               kif.key_out, kif.key_flag);
    end
    tick(2);
    rst_n = 1'b1;
    flag_q.push_back(cyc + LAT);
    tick(LAT + 3);
    chk_out("reset_prs_repress", 1'b0);
    release_key();
    tick(LAT + 4);
  endtask

  task automatic test_long_hold();
    press();
    tick(LAT);
    for (int i = 0; i < 100 - LAT; i++) begin
      @(negedge clk);
      tests++;
      if (kif.key_out !== 1'b0 || dut.r_cnt !== '0) begin
        fails++;
        $display("FAIL long_hold: key_out=%b cnt=%0d, required 0/0",
                 kif.key_out, dut.r_cnt);
      end
    end
    tick(1);
    release_key();
    tick(LAT + 4);
  endtask

  task automatic test_drain();
    tests++;
    if (flag_q.size() != 0 || rel_q.size() != 0) begin
      fails++;
      $display("FAIL missing_pulses: %0d press / %0d release pending, required 0/0",
               flag_q.size(), rel_q.size());
    end
  endtask

  initial begin
    cyc       = 0;
    tests     = 0;
    fails     = 0;
    mon_en    = 1'b0;
    prev_flag = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_min_hold();
    test_reset_mid();
    test_long_hold();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
